// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if
// Groups the producer handshakes (ALU, LSU) and the registered common data
// bus into one bundle.
//   master : producer/consumer side (drives *_valid and payloads, sees
//            *_ready and the cdb_* broadcast)
//   slave  : the arbiter itself
// Signals:
//   alu_valid/alu_ready/alu_ins_id/alu_value/alu_next_PC  ALU result handshake
//   lsu_valid/lsu_ready/lsu_ins_id/lsu_value              LSU result handshake
//   cdb_valid/cdb_src/cdb_ins_id/cdb_value/cdb_next_PC    broadcast bus
interface cdb_arbiter_if #(
  parameter int ID_WIDTH   = 3,
  parameter int DATA_WIDTH = 32
);
  logic                  alu_valid;
  logic                  alu_ready;
  logic [ID_WIDTH-1:0]   alu_ins_id;
  logic [DATA_WIDTH-1:0] alu_value;
  logic [DATA_WIDTH-1:0] alu_next_PC;

  logic                  lsu_valid;
  logic                  lsu_ready;
  logic [ID_WIDTH-1:0]   lsu_ins_id;
  logic [DATA_WIDTH-1:0] lsu_value;

  logic                  cdb_valid;
  logic                  cdb_src;
  logic [ID_WIDTH-1:0]   cdb_ins_id;
  logic [DATA_WIDTH-1:0] cdb_value;
  logic [DATA_WIDTH-1:0] cdb_next_PC;

  modport master (
    output alu_valid, alu_ins_id, alu_value, alu_next_PC,
    output lsu_valid, lsu_ins_id, lsu_value,
    input  alu_ready, lsu_ready,
    input  cdb_valid, cdb_src, cdb_ins_id, cdb_value, cdb_next_PC
  );

  modport slave (
    input  alu_valid, alu_ins_id, alu_value, alu_next_PC,
    input  lsu_valid, lsu_ins_id, lsu_value,
    output alu_ready, lsu_ready,
    output cdb_valid, cdb_src, cdb_ins_id, cdb_value, cdb_next_PC
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
// Shares the single common data bus between the ALU and the LSU. Each
// producer owns a one-entry holding register behind a valid/ready handshake;
// every cycle one held result is granted onto the registered CDB.
// Ports:
//   clk_in         system clock
//   rst_in         synchronous, active-high reset (wins over rdy_in)
//   rdy_in         global ready; all state frozen and readies low when 0
//   flush_pipline  discards held and outgoing results
//   bus            cdb_arbiter_if.slave (producer handshakes + CDB outputs)
// Build option:
//   CDB_LSU_PRIORITY_EN  defined   -> LSU always wins a tie (fixed priority)
//                        undefined -> round-robin between ALU and LSU
module cdb_arbiter #(
  parameter int ID_WIDTH   = 3,
  parameter int DATA_WIDTH = 32
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           rdy_in,
  input  logic           flush_pipline,
  cdb_arbiter_if.slave   bus
);

  logic                  r_aluHoldValid;
  logic [ID_WIDTH-1:0]   r_aluHoldId;
  logic [DATA_WIDTH-1:0] r_aluHoldValue;
  logic [DATA_WIDTH-1:0] r_aluHoldNextPc;

  logic                  r_lsuHoldValid;
  logic [ID_WIDTH-1:0]   r_lsuHoldId;
  logic [DATA_WIDTH-1:0] r_lsuHoldValue;

  logic                  r_cdbValid;
  logic                  r_cdbSrc;
  logic [ID_WIDTH-1:0]   r_cdbId;
  logic [DATA_WIDTH-1:0] r_cdbValue;
  logic [DATA_WIDTH-1:0] r_cdbNextPc;

  logic                  w_grantAlu;
  logic                  w_grantLsu;
  logic                  w_aluReady;
  logic                  w_lsuReady;
  logic                  w_aluAccept;
  logic                  w_lsuAccept;

`ifndef CDB_LSU_PRIORITY_EN
  // Source that won the most recent grant: 0 = ALU, 1 = LSU.
  logic                  r_rrLast;
`endif

  // Grant is derived purely from the holding registers so that no producer
  // valid input can ripple through to a ready output. A lone valid hold
  // always wins; a tie is broken by the arbitration policy.
  always_comb begin
    w_grantAlu = 1'b0;
    w_grantLsu = 1'b0;
    if (r_aluHoldValid && r_lsuHoldValid) begin
`ifdef CDB_LSU_PRIORITY_EN
      w_grantLsu = 1'b1;
`else
      w_grantAlu = r_rrLast;
      w_grantLsu = ~r_rrLast;
`endif
    end else begin
      w_grantAlu = r_aluHoldValid;
      w_grantLsu = r_lsuHoldValid;
    end
  end

  // A hold can take a new result when it is empty or is being drained this
  // cycle, which is what lets a single producer stream at full rate.
  assign w_aluReady  = rdy_in & ~flush_pipline & (~r_aluHoldValid | w_grantAlu);
  assign w_lsuReady  = rdy_in & ~flush_pipline & (~r_lsuHoldValid | w_grantLsu);
  assign w_aluAccept = bus.alu_valid & w_aluReady;
  assign w_lsuAccept = bus.lsu_valid & w_lsuReady;

  // ALU holding register: a same-cycle refill takes precedence over the
  // clear caused by its own grant, so the old entry leaves on the CDB while
  // the new one is captured.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_aluHoldValid  <= 1'b0;
      r_aluHoldId     <= '0;
      r_aluHoldValue  <= '0;
      r_aluHoldNextPc <= '0;
    end else if (rdy_in) begin
      if (flush_pipline) begin
        r_aluHoldValid <= 1'b0;
      end else if (w_aluAccept) begin
        r_aluHoldValid  <= 1'b1;
        r_aluHoldId     <= bus.alu_ins_id;
        r_aluHoldValue  <= bus.alu_value;
        r_aluHoldNextPc <= bus.alu_next_PC;
      end else if (w_grantAlu) begin
        r_aluHoldValid <= 1'b0;
      end
    end
  end

  // LSU holding register: same refill/drain behaviour as the ALU side, but
  // loads and stores never redirect the PC so no next-PC field is kept.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_lsuHoldValid <= 1'b0;
      r_lsuHoldId    <= '0;
      r_lsuHoldValue <= '0;
    end else if (rdy_in) begin
      if (flush_pipline) begin
        r_lsuHoldValid <= 1'b0;
      end else if (w_lsuAccept) begin
        r_lsuHoldValid <= 1'b1;
        r_lsuHoldId    <= bus.lsu_ins_id;
        r_lsuHoldValue <= bus.lsu_value;
      end else if (w_grantLsu) begin
        r_lsuHoldValid <= 1'b0;
      end
    end
  end

  // Registered CDB: the granted entry is copied out; with no grant only the
  // valid bit drops and the payload fields keep their last contents. A flush
  // kills whatever would have been broadcast this edge.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_cdbValid  <= 1'b0;
      r_cdbSrc    <= 1'b0;
      r_cdbId     <= '0;
      r_cdbValue  <= '0;
      r_cdbNextPc <= '0;
    end else if (rdy_in) begin
      if (flush_pipline) begin
        r_cdbValid <= 1'b0;
      end else if (w_grantAlu) begin
        r_cdbValid  <= 1'b1;
        r_cdbSrc    <= 1'b0;
        r_cdbId     <= r_aluHoldId;
        r_cdbValue  <= r_aluHoldValue;
        r_cdbNextPc <= r_aluHoldNextPc;
      end else if (w_grantLsu) begin
        r_cdbValid  <= 1'b1;
        r_cdbSrc    <= 1'b1;
        r_cdbId     <= r_lsuHoldId;
        r_cdbValue  <= r_lsuHoldValue;
        r_cdbNextPc <= '0;
      end else begin
        r_cdbValid <= 1'b0;
      end
    end
  end

`ifndef CDB_LSU_PRIORITY_EN
  // Round-robin memory: starts at LSU so the ALU takes the first tie, and is
  // left untouched by a flush so fairness carries across pipeline restarts.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_rrLast <= 1'b1;
    end else if (rdy_in && !flush_pipline) begin
      if (w_grantAlu) begin
        r_rrLast <= 1'b0;
      end else if (w_grantLsu) begin
        r_rrLast <= 1'b1;
      end
    end
  end
`endif

  assign bus.alu_ready   = w_aluReady;
  assign bus.lsu_ready   = w_lsuReady;
  assign bus.cdb_valid   = r_cdbValid;
  assign bus.cdb_src     = r_cdbSrc;
  assign bus.cdb_ins_id  = r_cdbId;
  assign bus.cdb_value   = r_cdbValue;
  assign bus.cdb_next_PC = r_cdbNextPc;

endmodule
